regfile_port_ctrl: RTL and testbench

REGFILE_PORT_CTRL -- requirements
Module: regfile_port_ctrl

---
 rtl/regfile_port_ctrl.sv | 98 +++++++++
 tb/tb_regfile_port_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_ctrl.sv
// Register-file write port controller: zeroing sweep after reset/clear, then round-robin
// arbitration of two writeback requesters onto one registered write port (1-cycle latency).
module regfile_port_ctrl #(
  parameter int WORD    = 32,
  parameter int REG_NUM = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb0_req,
  input  logic [4:0]      wb0_reg,
  input  logic [WORD-1:0] wb0_data,
  output logic            wb0_ready,
  input  logic            wb1_req,
  input  logic [4:0]      wb1_reg,
  input  logic [WORD-1:0] wb1_data,
  output logic            wb1_ready,
  input  logic            clear_req,
  output logic            rf_write_en,
  output logic [4:0]      rf_write_reg,
  output logic [WORD-1:0] rf_write_data,
  output logic            busy
);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [4:0] LAST = 5'(REG_NUM - 1);

  logic [0:0]      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            prio_q, prio_d;
  logic            en_q, en_d;
  logic [4:0]      reg_q, reg_d;
  logic [WORD-1:0] data_q, data_d;

  logic run_ok;
  logic xfer0, xfer1;

  // Reset is folded in so the ports look idle/busy while rst is held, even from RUN.
  assign run_ok    = !rst && (state_q == RUN) && !clear_req;
  assign wb0_ready = run_ok && wb0_req && (!wb1_req || !prio_q);
  assign wb1_ready = run_ok && wb1_req && (!wb0_req || prio_q);
  assign xfer0     = wb0_req && wb0_ready;
  assign xfer1     = wb1_req && wb1_ready;
  assign busy      = rst || (state_q == INIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    en_d    = 1'b0;
    reg_d   = reg_q;
    data_d  = data_q;
    if (state_q == INIT) begin
      en_d   = 1'b1;
      reg_d  = cnt_q;
      data_d = '0;
      cnt_d  = cnt_q + 5'd1;
      if (cnt_q == LAST) state_d = RUN;
    end else if (clear_req) begin
      state_d = INIT;
      cnt_d   = '0;
    end else if (xfer0) begin
      // Register 0 stays hard-wired to zero: accept the beat but suppress the write.
      en_d   = (wb0_reg != 5'd0);
      reg_d  = wb0_reg;
      data_d = wb0_data;
      prio_d = 1'b1;
    end else if (xfer1) begin
      en_d   = (wb1_reg != 5'd0);
      reg_d  = wb1_reg;
      data_d = wb1_data;
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      en_q    <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      en_q    <= en_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
    end
  end

  assign rf_write_en   = en_q;
  assign rf_write_reg  = reg_q;
  assign rf_write_data = data_q;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: directed stimulus pushes expected writes (index, data, cycle)
// into a queue; a negedge monitor pops and compares every registered write.
module tb_regfile_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb0_req, wb1_req, clear_req;
  logic [4:0]  wb0_reg, wb1_reg;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready;
  logic        rf_write_en;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    int          c;
  } exp_t;
  exp_t exp_q[$];

  regfile_port_ctrl #(.WORD(32), .REG_NUM(32)) dut (
    .clk(clk), .rst(rst),
    .wb0_req(wb0_req), .wb0_reg(wb0_reg), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_req(wb1_req), .wb1_reg(wb1_reg), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .clear_req(clear_req),
    .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d, input int c);
    exp_t e;
    e.r = r; e.d = d; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic push_sweep(input int first, input int last);
    for (int i = first; i <= last; i++) push(5'(i), 32'h0, cyc + 1 + i);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every registered write must match the head of the queue, including its cycle.
  always @(negedge clk) begin
    if (rf_write_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write at cycle %0d: got reg %0d data %h, expected none",
                 cyc, rf_write_reg, rf_write_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rf_write_reg !== e.r || rf_write_data !== e.d || cyc != e.c) begin
          n_err++;
          $display("FAIL write at cycle %0d: got reg %0d data %h, expected reg %0d data %h cycle %0d",
                   cyc, rf_write_reg, rf_write_data, e.r, e.d, e.c);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clear_req = 1'b0;
    wb0_req = 1'b1; wb0_reg = 5'd3; wb0_data = 32'hAAAA0000;
    wb1_req = 1'b0; wb1_reg = 5'd5; wb1_data = 32'h5555FFFF;
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_wb0_ready", 32'(wb0_ready), 32'd0);
    tick(2);
    chk("rst_write_en", 32'(rf_write_en), 32'd0);
    chk("rst_write_reg", 32'(rf_write_reg), 32'd0);

    // Reset sweep: 32 zero writes, ready held low throughout.
    rst = 1'b0; wb0_req = 1'b0;
    push_sweep(0, 31);
    for (int i = 0; i < 32; i++) begin
      if (i == 5) begin
        wb1_req = 1'b1;
        #1;
        chk("sweep_wb1_ready", 32'(wb1_ready), 32'd0);
        chk("sweep_busy", 32'(busy), 32'd1);
        wb1_req = 1'b0;
      end
      tick(1);
    end
    chk("sweep_busy_fall", 32'(busy), 32'd0);
    tick(1);
    chk("idle_write_en", 32'(rf_write_en), 32'd0);

    // Contention: grants alternate starting with wb0.
    wb0_req = 1'b1; wb1_req = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("cont_wb0_ready", 32'(wb0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_wb1_ready", 32'(wb1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 0) push(5'd3, 32'hAAAA0000, cyc + 1);
      else            push(5'd5, 32'h5555FFFF, cyc + 1);
      tick(1);
    end
    wb0_req = 1'b0; wb1_req = 1'b0;

    // Register 0: accepted, but no write issued.
    wb1_req = 1'b1; wb1_reg = 5'd0; wb1_data = 32'hDEADBEEF;
    #1;
    chk("r0_wb1_ready", 32'(wb1_ready), 32'd1);
    tick(1);
    wb1_req = 1'b0;
    chk("r0_write_en", 32'(rf_write_en), 32'd0);
    tick(1);

    // Sole wb1 write, then contention: prio points at wb0 again.
    wb1_req = 1'b1; wb1_reg = 5'd9; wb1_data = 32'h12345678;
    #1;
    chk("sole_wb1_ready", 32'(wb1_ready), 32'd1);
    push(5'd9, 32'h12345678, cyc + 1);
    tick(1);
    wb0_req = 1'b1; wb0_reg = 5'd6; wb0_data = 32'hCAFE0006;
    #1;
    chk("prio_wb0_ready", 32'(wb0_ready), 32'd1);
    chk("prio_wb1_ready", 32'(wb1_ready), 32'd0);
    push(5'd6, 32'hCAFE0006, cyc + 1);
    tick(1);
    wb1_req = 1'b0;

    // Mid-run clear with wb0 requesting (prio now 1, wb0 sole requester).
    wb0_reg = 5'd4; wb0_data = 32'h11112222; clear_req = 1'b1;
    #1;
    chk("clr_wb0_ready", 32'(wb0_ready), 32'd0);
    tick(1);
    clear_req = 1'b0;
    chk("clr_write_en", 32'(rf_write_en), 32'd0);
    push_sweep(0, 31);
    for (int i = 0; i < 32; i++) begin
      if (i == 0 || i == 31) begin
        chk("clr_busy", 32'(busy), 32'd1);
        chk("clr_sweep_wb0_ready", 32'(wb0_ready), 32'd0);
      end
      tick(1);
    end
    chk("clr_busy_fall", 32'(busy), 32'd0);
    chk("clr_first_run_wb0_ready", 32'(wb0_ready), 32'd1);
    push(5'd4, 32'h11112222, cyc + 1);
    tick(1);
    wb0_req = 1'b0;
    tick(1);

    // Mid-sweep reset at index 17 (prio is 1 going in).
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    push_sweep(0, 16);
    tick(17);
    rst = 1'b1;
    wb0_req = 1'b1; wb0_reg = 5'd3; wb0_data = 32'hAAAA0000;
    wb1_req = 1'b1; wb1_reg = 5'd5; wb1_data = 32'h5555FFFF;
    #1;
    chk("msr_busy", 32'(busy), 32'd1);
    chk("msr_wb1_ready", 32'(wb1_ready), 32'd0);
    tick(1);
    rst = 1'b0;
    push_sweep(0, 31);

    // Clear at sweep index 10 must not restart the sweep.
    tick(10);
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    tick(21);
    chk("msr_wb0_first", 32'(wb0_ready), 32'd1);
    chk("msr_wb1_first", 32'(wb1_ready), 32'd0);
    push(5'd3, 32'hAAAA0000, cyc + 1);
    tick(1);
    chk("msr_wb1_second", 32'(wb1_ready), 32'd1);
    push(5'd5, 32'h5555FFFF, cyc + 1);
    tick(1);
    wb0_req = 1'b0; wb1_req = 1'b0;
    tick(4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
